dzline_uart: RTL and testbench

DZLINE_UART -- requirements
Module: dzline_uart

---
 rtl/dzline_uart.sv | 194 +++++++++++++++++++
 tb/tb_dzline_uart.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dzline_uart.sv
// DZ-style serial line: 8N1 transmitter and receiver sharing one runtime bit-time divisor.
// Each direction latches its own copy of the divisor at frame start, so the two never interact.
module dzline_uart #(
    parameter int DIVW  = 16,
    parameter int SYNCN = 2
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic [DIVW-1:0] divisor,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            txd,
    input  logic            rxd,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    input  logic            rx_ack,
    output logic            rx_overrun,
    output logic            rx_framerr
);

    localparam logic [DIVW-1:0] DMIN = DIVW'(4);
    localparam logic [DIVW-1:0] ONE  = DIVW'(1);

    logic [DIVW-1:0] d_eff;
    assign d_eff = (divisor < DMIN) ? DMIN : divisor;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t       tx_state;
    logic [DIVW-1:0] tx_div;
    logic [DIVW-1:0] tx_cnt;
    logic [7:0]      tx_shift;
    logic [2:0]      tx_bit;
    logic            tx_go;

    assign tx_go = tx_valid & tx_ready;

    // tx_ready is registered and only ever high in IDLE or the last STOP cycle, so tx_go starts back-to-back frames too.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
        end else if (tx_go) begin
            tx_state <= TX_START;
            tx_div   <= d_eff;
            tx_cnt   <= d_eff - ONE;
            tx_shift <= tx_data;
            tx_bit   <= '0;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                end
                TX_START, TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= tx_div - ONE;
                        if (tx_state == TX_DATA && tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            txd      <= 1'b1;
                        end else begin
                            if (tx_state == TX_DATA) begin
                                tx_bit <= tx_bit + 3'd1;
                            end
                            tx_state <= TX_DATA;
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - ONE;
                        if (tx_cnt == ONE) begin
                            tx_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic [SYNCN-1:0] rx_sync;
    logic             rs;
    logic             rs_prev;
    rx_state_t        rx_state;
    logic [DIVW-1:0]  rx_div;
    logic [DIVW-1:0]  rx_cnt;
    logic [7:0]       rx_shift;
    logic [2:0]       rx_bit;

    assign rs = rx_sync[SYNCN-1];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_sync <= '1;
            rs_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNCN-2:0], rxd};
            rs_prev <= rs;
        end
    end

    // Samples land mid-bit: first at D/2 into the start bit, then every D cycles through the stop bit.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_state   <= RX_IDLE;
            rx_div     <= '0;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            rx_bit     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_framerr <= 1'b0;
        end else begin
            rx_framerr <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rs && rs_prev) begin
                        rx_state <= RX_START;
                        rx_div   <= d_eff;
                        rx_cnt   <= (d_eff >> 1) - ONE;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rs ? RX_IDLE : RX_DATA;
                        rx_cnt   <= rx_div - ONE;
                        rx_bit   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rs, rx_shift[7:1]};
                        rx_cnt   <= rx_div - ONE;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        if (rs) begin
                            rx_state <= RX_IDLE;
                            if (!rx_valid || rx_ack) begin
                                rx_data  <= rx_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            rx_state   <= RX_BREAK;
                            rx_framerr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                RX_BREAK: begin
                    if (rs) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dzline_uart.sv
// Directed bench for dzline_uart: transmit waveform timing, receive framing/overrun/break,
// false starts, divisor clamping, loopback and mid-frame reset.
module tb_dzline_uart;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [15:0] divisor;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        rxd;
    logic        rxd_drv;
    logic        loop_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        rx_overrun;
    logic        rx_framerr;

    int checks = 0;
    int errors = 0;
    int framerrCount = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    dzline_uart #(.DIVW(16), .SYNCN(2)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .divisor    (divisor),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .rx_framerr (rx_framerr)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (rx_framerr === 1'b1) framerrCount++;
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame on rxd, bitLen cycles per bit.
    task automatic applyStimulus(input logic [7:0] b, input int bitLen);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = frame[i];
            repeat (bitLen) tick;
        end
    endtask

    // Handshake in cycle 0, then compare txd in every cycle of the frame against the ideal waveform.
    task automatic checkTxFrame(input logic [7:0] data, input logic [15:0] divIn, input int dM,
                                input logic [15:0] divAfter, input bit noise);
        int idx;
        logic expTxd;
        divisor  = divIn;
        tx_data  = data;
        tx_valid = 1'b1;
        checkOutput("tx_ready_accept", tx_ready, 1);
        for (int c = 1; c <= 10 * dM; c++) begin
            tick;
            if (c == 1) begin
                divisor  = divAfter;
                tx_valid = noise;
                tx_data  = noise ? ~data : data;
            end
            if (c == 10 * dM - 1) tx_valid = 1'b0;
            if (c <= dM) expTxd = 1'b0;
            else if (c <= 9 * dM) begin
                idx = (c - dM - 1) / dM;
                expTxd = data[idx];
            end else expTxd = 1'b1;
            checkOutput($sformatf("txd_c%0d", c), txd, expTxd);
            if (c == 10 * dM - 1) checkOutput("tx_ready_penult", tx_ready, 0);
            if (c == 10 * dM) checkOutput("tx_ready_last", tx_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fe0;
        int got;
        logic [7:0] loopExp [2];
        RESET    = 1'b1;
        divisor  = 16'd16;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rxd_drv  = 1'b1;
        loop_en  = 1'b0;
        rx_ack   = 1'b0;
        repeat (3) tick;
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_overrun", rx_overrun, 0);
        checkOutput("rst_rx_framerr", rx_framerr, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        RESET = 1'b0;
        tick;

        checkTxFrame(8'h55, 16'd10, 10, 16'd10, 1'b0);
        tick;
        checkTxFrame(8'hB2, 16'd8, 8, 16'd20, 1'b1);
        repeat (3) tick;
        checkOutput("tx_idle_after_noise_txd", txd, 1);
        checkOutput("tx_idle_after_noise_ready", tx_ready, 1);
        checkTxFrame(8'hC3, 16'd2, 4, 16'd2, 1'b0);
        tick;

        divisor = 16'd16;
        applyStimulus(8'h41, 16);
        repeat (4) tick;
        checkOutput("rx1_valid", rx_valid, 1);
        checkOutput("rx1_data", rx_data, 8'h41);
        checkOutput("rx1_overrun", rx_overrun, 0);
        applyStimulus(8'h42, 16);
        repeat (4) tick;
        checkOutput("ovr_valid", rx_valid, 1);
        checkOutput("ovr_data", rx_data, 8'h41);
        checkOutput("ovr_flag", rx_overrun, 1);
        rx_ack = 1'b1;
        tick;
        rx_ack = 1'b0;
        checkOutput("ack_valid_clr", rx_valid, 0);
        checkOutput("ack_overrun_clr", rx_overrun, 0);
        rx_ack = 1'b1;
        tick;
        rx_ack = 1'b0;
        checkOutput("idle_ack_valid", rx_valid, 0);
        checkOutput("idle_ack_overrun", rx_overrun, 0);

        fe0 = framerrCount;
        rxd_drv = 1'b0;
        repeat (15 * 16) tick;
        checkOutput("brk_framerr_pulses", framerrCount - fe0, 1);
        checkOutput("brk_valid", rx_valid, 0);
        rxd_drv = 1'b1;
        repeat (32) tick;
        applyStimulus(8'h5A, 16);
        repeat (4) tick;
        checkOutput("brk_after_valid", rx_valid, 1);
        checkOutput("brk_after_data", rx_data, 8'h5A);
        checkOutput("brk_total_pulses", framerrCount - fe0, 1);
        rx_ack = 1'b1;
        tick;
        rx_ack = 1'b0;

        fe0 = framerrCount;
        rxd_drv = 1'b0;
        repeat (4) tick;
        rxd_drv = 1'b1;
        repeat (20 * 16) tick;
        checkOutput("false_start_valid", rx_valid, 0);
        checkOutput("false_start_overrun", rx_overrun, 0);
        checkOutput("false_start_framerr", framerrCount - fe0, 0);

        divisor = 16'd2;
        applyStimulus(8'h96, 4);
        repeat (4) tick;
        checkOutput("clamp_rx_valid", rx_valid, 1);
        checkOutput("clamp_rx_data", rx_data, 8'h96);
        checkOutput("clamp_rx_framerr", framerrCount - fe0, 0);
        rx_ack = 1'b1;
        tick;
        rx_ack = 1'b0;

        divisor = 16'd16;
        loop_en = 1'b1;
        loopExp[0] = 8'hA3;
        loopExp[1] = 8'h0F;
        fe0 = framerrCount;
        got = 0;
        tick;
        fork
            begin
                tx_data  = 8'hA3;
                tx_valid = 1'b1;
                for (int i = 0; i < 50 && !tx_ready; i++) tick;
                tick;
                tx_data = 8'h0F;
                for (int i = 0; i < 400 && !tx_ready; i++) tick;
                checkOutput("loop_tx_ready", tx_ready, 1);
                tick;
                tx_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 800 && got < 2; i++) begin
                    tick;
                    rx_ack = 1'b0;
                    if (rx_valid) begin
                        checkOutput($sformatf("loop_rx_data%0d", got), rx_data, loopExp[got]);
                        if (rx_overrun) checkOutput("loop_overrun", rx_overrun, 0);
                        got++;
                        rx_ack = 1'b1;
                    end
                end
                tick;
                rx_ack = 1'b0;
            end
        join
        checkOutput("loop_rx_count", got, 2);
        checkOutput("loop_framerr", framerrCount - fe0, 0);
        checkOutput("loop_overrun_end", rx_overrun, 0);
        loop_en = 1'b0;
        repeat (4) tick;

        divisor  = 16'd10;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        checkOutput("rst_mid_accept", tx_ready, 1);
        tick;
        tx_valid = 1'b0;
        repeat (39) tick;
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        checkOutput("rst_mid_txd", txd, 1);
        checkOutput("rst_mid_ready", tx_ready, 1);
        tick;
        checkOutput("rst_mid_txd_next", txd, 1);
        checkTxFrame(8'h3C, 16'd10, 10, 16'd10, 1'b0);
        tick;
        checkOutput("final_idle_txd", txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
